ledr_pio_arbiter: RTL and testbench
===================================

# ledr_pio_arbiter

Shares the 10-bit LEDR PIO slave between several on-chip requesters (e.g. NIOS software mirror, GNC status encoder, heartbeat generator) on the DE10-Lite SoC. It drives the PIO's Avalon-MM slave port directly and grants requesters round-robin. Each grant performs one write and an immediate readback verify, then holds the pattern for a programmable minimum dwell so patterns stay visible to a human.

## Interface
- NUM_REQ, 3, number of requesters (2..4)
- LED_W, 10, LED pattern width; must equal PIO out_port width
- MIN_HOLD, 0, minimum IDLE cycles after a completed grant before the next arbitration (0..2^16-1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held until ack
- req_data  in  NUM_REQ*LED_W  per-requester pattern; slice i = bits [i*LED_W +: LED_W]
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- busy  out  1  high in any state other than IDLE
- owner  out  2  index of the last granted requester
- verify_err  out  1  one-cycle pulse with ack when readback mismatched
- err_count  out  8  saturating count of verify failures
- chipselect  out  1  to PIO
- write_n  out  1  to PIO, active-low
- address  out  2  to PIO; always 0
- writedata  out  32  to PIO; {22'b0, pattern}
- readdata  in  32  from PIO, combinational in the PIO

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE: if dwell==0 and |req, select the winner as the first asserted requester scanning upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...). Latch idx and req_data slice, set owner=idx, go to WRITE. If dwell!=0, decrement it and do not arbitrate.
- WRITE: chipselect=1, write_n=0, address=0, writedata={0, latched data}. Go to READ.
- READ: chipselect=1, write_n=1, address=0. Mismatch = (readdata[LED_W-1:0] != latched) or (readdata[31:LED_W] != 0). Register the mismatch and go to DONE.
- DONE: chipselect=0. Set ack[idx]=1. Set verify_err=mismatch. If mismatch and err_count<255, increment err_count. Set rr_ptr = (idx+1) mod NUM_REQ and dwell = MIN_HOLD. Go to IDLE.
- Data is latched at the grant. Changes to req_data or deassertion of req after the grant do not affect the transaction, and ack is still pulsed.
- Requesters that are not granted keep waiting. No request is dropped.
- Outside WRITE and READ: chipselect=0, write_n=1, address=0. writedata holds its last value.

## Timing
- Reset values: state IDLE, chipselect 0, write_n 1, address 0, writedata 0, ack 0, busy 0, owner 0, verify_err 0, err_count 0, rr_ptr 0, dwell 0.
- Grant decided in IDLE at cycle t. Write strobe at t+1, read at t+2, ack/verify_err at t+3, back in IDLE at t+4.
- With MIN_HOLD=0 the next grant can occur at t+4 (4-cycle period). With MIN_HOLD=H the next grant is at t+4+H.
- PIO register updates at the end of WRITE, so READ sees the new value in the same cycle.
- A requester that keeps req high after its ack is eligible again only after the round-robin pointer passes it. With all requesters active, grants go 0,1,2,0,...
- If reset is asserted mid-transaction, the next edge forces reset values: no ack, bus idle. The PIO keeps whatever was already written.
- Simultaneous: req rising during DONE is seen in the following IDLE. err_count saturates at 255 and never wraps.

## Test plan
- Reset, then req=3'b001 with data0=10'h155, MIN_HOLD=0: write of 32'h155 at t+1, read at t+2, ack=001 at t+3, verify_err=0, PIO out_port=10'h155.
- req=3'b111 held with data 10'h001/10'h002/10'h004: acks in order 001,010,100,001, spaced 4 cycles; owner=0,1,2,0.
- MIN_HOLD=5, two back-to-back requests: second write strobe exactly 9 cycles after the first.
- Faulty PIO model returns readdata=32'h400 for a write of 10'h000: verify_err pulses with ack, err_count=1. 300 such failures leave err_count=255.
- req dropped and req_data changed in the WRITE cycle: writedata still equals the value at grant, ack still pulses.
- reset asserted in READ: next cycle chipselect=0, ack=0, err_count=0, state IDLE. A pending req is granted to requester 0 first.

Source files
------------

// File: rtl/ledr_pio_arbiter.sv
// Round-robin arbiter sharing the LEDR PIO slave: each grant writes a pattern,
// reads it back to verify, then holds the bus idle for a programmable dwell.
module ledr_pio_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int LED_W    = 10,
   parameter int MIN_HOLD = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LED_W-1:0] req_data,
   output logic [NUM_REQ-1:0]       ack,
   output logic                     busy,
   output logic [1:0]               owner,
   output logic                     verify_err,
   output logic [7:0]               err_count,
   output logic                     chipselect,
   output logic                     write_n,
   output logic [1:0]               address,
   output logic [31:0]              writedata,
   input  logic [31:0]              readdata
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   localparam logic [1:0]  LAST_IDX = 2'(NUM_REQ - 1);
   localparam logic [2:0]  NREQ3    = 3'(NUM_REQ);
   localparam logic [15:0] HOLD     = 16'(MIN_HOLD);

   state_t             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [LED_W-1:0]   data_q, data_d;
   logic               mismatch_q, mismatch_d;
   logic [1:0]         rr_q, rr_d;
   logic [15:0]        dwell_q, dwell_d;
   logic [1:0]         owner_q, owner_d;
   logic [7:0]         err_q, err_d;
   logic [31:0]        wdata_q, wdata_d;

   logic [1:0]         cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_hit;
   logic               win_valid;
   logic [1:0]         win_idx;
   logic [LED_W-1:0]   win_data;

   // Candidate gi is the requester gi positions after the round-robin pointer.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
      logic [2:0] sum;
      assign sum           = {1'b0, rr_q} + 3'(gi);
      assign cand_idx[gi]  = (sum >= NREQ3) ? 2'(sum - NREQ3) : sum[1:0];
      assign cand_hit[gi]  = req[cand_idx[gi]];
   end

   always_comb begin
      win_valid = 1'b0;
      win_idx   = 2'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            win_valid = 1'b1;
            win_idx   = cand_idx[k];
         end
      end
   end

   assign win_data = req_data[win_idx*LED_W +: LED_W];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      data_d     = data_q;
      mismatch_d = mismatch_q;
      rr_d       = rr_q;
      dwell_d    = dwell_q;
      owner_d    = owner_q;
      err_d      = err_q;
      wdata_d    = wdata_q;
      case (state_q)
         IDLE: begin
            if (dwell_q != 16'd0) begin
               dwell_d = dwell_q - 16'd1;
            end else if (win_valid) begin
               idx_d   = win_idx;
               data_d  = win_data;
               owner_d = win_idx;
               wdata_d = {{(32-LED_W){1'b0}}, win_data};
               state_d = WRITE;
            end
         end
         WRITE: state_d = READ;
         READ: begin
            // The PIO register was updated at the end of WRITE, so readback is current.
            mismatch_d = (readdata[LED_W-1:0] != data_q) ||
                         (readdata[31:LED_W] != '0);
            state_d    = DONE;
         end
         DONE: begin
            if (mismatch_q && (err_q != 8'hFF)) err_d = err_q + 8'd1;
            rr_d    = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
            dwell_d = HOLD;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= 2'd0;
         data_q     <= '0;
         mismatch_q <= 1'b0;
         rr_q       <= 2'd0;
         dwell_q    <= 16'd0;
         owner_q    <= 2'd0;
         err_q      <= 8'd0;
         wdata_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         mismatch_q <= mismatch_d;
         rr_q       <= rr_d;
         dwell_q    <= dwell_d;
         owner_q    <= owner_d;
         err_q      <= err_d;
         wdata_q    <= wdata_d;
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign ack[gi] = (state_q == DONE) && (idx_q == 2'(gi));
   end

   assign busy       = (state_q != IDLE);
   assign owner      = owner_q;
   assign verify_err = (state_q == DONE) && mismatch_q;
   assign err_count  = err_q;
   assign chipselect = (state_q == WRITE) || (state_q == READ);
   assign write_n    = (state_q != WRITE);
   assign address    = 2'b00;
   assign writedata  = wdata_q;

endmodule

// File: tb/tb_ledr_pio_arbiter.sv
// Bench for ledr_pio_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model, on one instance with no dwell and one with dwell 5.
module tb_ledr_pio_arbiter;
   localparam int N  = 3;
   localparam int W  = 10;
   localparam int H1 = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic           fault;

   logic [N-1:0] ack0, ack1;
   logic         busy0, busy1, ve0, ve1, cs0, cs1, wn0, wn1;
   logic [1:0]   own0, own1, ad0, ad1;
   logic [7:0]   ec0, ec1;
   logic [31:0]  wd0, wd1, rd0, rd1;
   logic [W-1:0] pio0 = '0;
   logic [W-1:0] pio1 = '0;

   int checks = 0;
   int errors = 0;

   ledr_pio_arbiter #(.NUM_REQ(N), .LED_W(W), .MIN_HOLD(0)) dut0 (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack0),
      .busy(busy0), .owner(own0), .verify_err(ve0), .err_count(ec0),
      .chipselect(cs0), .write_n(wn0), .address(ad0), .writedata(wd0), .readdata(rd0));

   ledr_pio_arbiter #(.NUM_REQ(N), .LED_W(W), .MIN_HOLD(H1)) dut1 (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack1),
      .busy(busy1), .owner(own1), .verify_err(ve1), .err_count(ec1),
      .chipselect(cs1), .write_n(wn1), .address(ad1), .writedata(wd1), .readdata(rd1));

   // PIO slave models: register updates on a write strobe, combinational readback.
   always @(posedge clk) if (cs0 && !wn0) pio0 <= wd0[W-1:0];
   always @(posedge clk) if (cs1 && !wn1) pio1 <= wd1[W-1:0];
   assign rd0 = fault ? 32'h400 : {22'b0, pio0};
   assign rd1 = fault ? 32'h400 : {22'b0, pio1};

   // Output view of the instance selected for randomized checking.
   int           sel = 0;
   logic [N-1:0] m_ack;
   logic         m_busy, m_ve, m_cs, m_wn;
   logic [1:0]   m_own, m_ad;
   logic [7:0]   m_ec;
   logic [31:0]  m_wd;
   assign m_ack  = (sel != 0) ? ack1  : ack0;
   assign m_busy = (sel != 0) ? busy1 : busy0;
   assign m_ve   = (sel != 0) ? ve1   : ve0;
   assign m_cs   = (sel != 0) ? cs1   : cs0;
   assign m_wn   = (sel != 0) ? wn1   : wn0;
   assign m_own  = (sel != 0) ? own1  : own0;
   assign m_ad   = (sel != 0) ? ad1   : ad0;
   assign m_ec   = (sel != 0) ? ec1   : ec0;
   assign m_wd   = (sel != 0) ? wd1   : wd0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      fault = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [52:0] exp;
      reset = 1'b1; req = '0; req_data = '0; fault = 1'b0;
      tick(); tick();
      exp = {1'b0, 1'b1, 2'b0, 32'b0, 3'b0, 1'b0, 2'b0, 1'b0, 8'b0};
      checks++;
      if ({cs0, wn0, ad0, wd0, ack0, busy0, own0, ve0, ec0} !== exp) begin
         errors++;
         $display("FAIL reset_state0 act=%h exp=%h", {cs0, wn0, ad0, wd0, ack0, busy0, own0, ve0, ec0}, exp);
      end
      checks++;
      if ({cs1, wn1, ad1, wd1, ack1, busy1, own1, ve1, ec1} !== exp) begin
         errors++;
         $display("FAIL reset_state1 act=%h exp=%h", {cs1, wn1, ad1, wd1, ack1, busy1, own1, ve1, ec1}, exp);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_after_reset act=%b exp=0", busy0); end
      $display("test_reset done");
   endtask

   task automatic test_single();
      req_data[W-1:0] = 10'h155;
      req = 3'b001;
      tick();
      checks++;
      if ({cs0, wn0, ad0} !== 4'b1000) begin errors++; $display("FAIL write_strobe act=%b exp=1000", {cs0, wn0, ad0}); end
      checks++;
      if (wd0 !== 32'h155) begin errors++; $display("FAIL write_data act=%h exp=155", wd0); end
      tick();
      checks++;
      if ({cs0, wn0, ad0} !== 4'b1100) begin errors++; $display("FAIL read_strobe act=%b exp=1100", {cs0, wn0, ad0}); end
      tick();
      checks++;
      if ({ack0, ve0, own0, busy0} !== {3'b001, 1'b0, 2'd0, 1'b1}) begin
         errors++; $display("FAIL single_ack act=%b exp=0010001", {ack0, ve0, own0, busy0});
      end
      req = '0;
      tick();
      checks++;
      if ({busy0, ack0, cs0} !== 5'b0) begin errors++; $display("FAIL single_idle act=%b exp=00000", {busy0, ack0, cs0}); end
      checks++;
      if (pio0 !== 10'h155) begin errors++; $display("FAIL pio_value act=%h exp=155", pio0); end
      $display("test_single done");
   endtask

   task automatic test_round_robin();
      logic [2:0] one;
      logic [2:0] exp;
      int n;
      int last;
      one = 3'b001;
      do_reset();
      req_data = {10'h004, 10'h002, 10'h001};
      req = 3'b111;
      n = 0; last = 0;
      for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
         tick();
         if (ack0 != 0) begin
            exp = one << (n % 3);
            checks++;
            if (ack0 !== exp) begin errors++; $display("FAIL rr_ack act=%b exp=%b", ack0, exp); end
            checks++;
            if (own0 !== 2'(n % 3)) begin errors++; $display("FAIL rr_owner act=%0d exp=%0d", own0, n % 3); end
            checks++;
            if (wd0 !== {29'b0, exp}) begin errors++; $display("FAIL rr_data act=%h exp=%h", wd0, exp); end
            if (n > 0) begin
               checks++;
               if (cyc - last != 4) begin errors++; $display("FAIL rr_spacing act=%0d exp=4", cyc - last); end
            end
            last = cyc;
            n++;
         end
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL rr_ack_count act=%0d exp=4", n); end
      req = '0;
      repeat (3) tick();
      $display("test_round_robin done acks=%0d", n);
   endtask

   task automatic test_min_hold();
      int first;
      int second;
      logic [31:0] wd_second;
      do_reset();
      req_data = {10'h000, 10'h0AA, 10'h055};
      req = 3'b011;
      first = -1; second = -1; wd_second = '0;
      for (int cyc = 0; cyc < 60 && second < 0; cyc++) begin
         tick();
         if (cs1 && !wn1) begin
            if (first < 0) first = cyc;
            else begin second = cyc; wd_second = wd1; end
         end
         if (ack1 != 0) req = req & ~ack1;
      end
      checks++;
      if (second < 0 || second - first != 9) begin
         errors++; $display("FAIL hold_gap act=%0d exp=9", second - first);
      end
      checks++;
      if (wd_second !== 32'h0AA) begin errors++; $display("FAIL hold_second_data act=%h exp=0aa", wd_second); end
      req = '0;
      repeat (12) tick();
      $display("test_min_hold done gap=%0d", second - first);
   endtask

   task automatic test_verify_err();
      int n;
      int exp_ec;
      do_reset();
      fault = 1'b1;
      req_data = '0;
      req = 3'b001;
      n = 0;
      for (int cyc = 0; cyc < 2000 && n < 300; cyc++) begin
         tick();
         checks++;
         if (ve0 !== (ack0 != 0)) begin errors++; $display("FAIL verify_pulse act=%b exp=%b", ve0, (ack0 != 0)); end
         if (ack0 != 0) begin
            n++;
            exp_ec = (n - 1 > 255) ? 255 : n - 1;
            checks++;
            if (ec0 !== 8'(exp_ec)) begin errors++; $display("FAIL err_count_track act=%0d exp=%0d", ec0, exp_ec); end
         end
      end
      tick();
      checks++;
      if (n != 300 || ec0 !== 8'd255) begin
         errors++; $display("FAIL err_count_sat act=%0d exp=255 acks=%0d", ec0, n);
      end
      req = '0; fault = 1'b0;
      repeat (2) tick();
      $display("test_verify_err done acks=%0d err_count=%0d", n, ec0);
   endtask

   task automatic test_data_latch();
      do_reset();
      req_data[2*W +: W] = 10'h3AA;
      req = 3'b100;
      tick();
      req = '0;
      req_data[2*W +: W] = 10'h055;
      checks++;
      if (wd0 !== 32'h3AA) begin errors++; $display("FAIL latch_data act=%h exp=3aa", wd0); end
      checks++;
      if (own0 !== 2'd2) begin errors++; $display("FAIL latch_owner act=%0d exp=2", own0); end
      tick(); tick();
      checks++;
      if ({ack0, ve0} !== 4'b1000) begin errors++; $display("FAIL latch_ack act=%b exp=1000", {ack0, ve0}); end
      tick();
      $display("test_data_latch done");
   endtask

   task automatic test_reset_mid();
      do_reset();
      fault = 1'b1;
      req = 3'b010;
      repeat (3) tick();
      req = '0;
      tick();
      checks++;
      if (ec0 !== 8'd1) begin errors++; $display("FAIL pre_err_count act=%0d exp=1", ec0); end
      fault = 1'b0;
      req_data[W +: W] = 10'h0F0;
      req = 3'b010;
      tick(); tick();
      reset = 1'b1;
      req = 3'b011;
      tick();
      checks++;
      if ({cs0, wn0, ack0, ec0, busy0} !== {1'b0, 1'b1, 3'b0, 8'b0, 1'b0}) begin
         errors++; $display("FAIL mid_reset act=%h exp=%h", {cs0, wn0, ack0, ec0, busy0}, {1'b0, 1'b1, 3'b0, 8'b0, 1'b0});
      end
      checks++;
      if (pio0 !== 10'h0F0) begin errors++; $display("FAIL pio_keeps act=%h exp=0f0", pio0); end
      reset = 1'b0;
      req_data[W-1:0] = 10'h111;
      tick();
      checks++;
      if ({own0, wd0} !== {2'd0, 32'h111}) begin errors++; $display("FAIL post_reset_grant act=%h exp=%h", {own0, wd0}, {2'd0, 32'h111}); end
      tick(); tick();
      checks++;
      if (ack0 !== 3'b001) begin errors++; $display("FAIL post_reset_ack act=%b exp=001", ack0); end
      req = '0;
      repeat (2) tick();
      $display("test_reset_mid done");
   endtask

   // Transaction-level reference: a phase counter walks grant, write, read, done;
   // grants go to the first pending requester at or after the pointer.
   task automatic test_random(input int s);
      int ph, dwell_m, w_m, rr_m, ec_m, hold, txns;
      logic [W-1:0] dat_m;
      logic [31:0]  wd_m;
      logic [1:0]   own_m;
      logic         mis_m, found, fault_s;
      logic [N-1:0] req_s, exp_ack;
      logic [N*W-1:0] data_s;
      sel = s;
      hold = (s != 0) ? H1 : 0;
      req_data = '0;
      do_reset();
      ph = 0; dwell_m = 0; w_m = 0; rr_m = 0; ec_m = 0; txns = 0;
      dat_m = '0; wd_m = '0; own_m = '0; mis_m = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         req_s = req; data_s = req_data; fault_s = fault;
         tick();
         case (ph)
            0: begin
               if (dwell_m > 0) dwell_m--;
               else if (req_s != 0) begin
                  found = 1'b0;
                  for (int k = 0; k < N; k++) begin
                     int c;
                     c = (rr_m + k) % N;
                     if (!found && req_s[c]) begin found = 1'b1; w_m = c; end
                  end
                  dat_m = data_s[w_m*W +: W];
                  own_m = 2'(w_m);
                  wd_m  = {22'b0, dat_m};
                  ph = 1;
               end
            end
            1: ph = 2;
            2: begin mis_m = fault_s; ph = 3; end
            default: begin
               if (mis_m && ec_m < 255) ec_m++;
               rr_m = (w_m + 1) % N;
               dwell_m = hold;
               ph = 0;
               txns++;
            end
         endcase
         exp_ack = (ph == 3) ? 3'(1 << w_m) : 3'b0;
         checks++;
         if ({m_cs, m_wn, m_ad, m_wd} !== {(ph == 1 || ph == 2), (ph != 1), 2'b0, wd_m}) begin
            errors++;
            $display("FAIL rand_bus cyc=%0d act=%h exp=%h", cyc, {m_cs, m_wn, m_ad, m_wd}, {(ph == 1 || ph == 2), (ph != 1), 2'b0, wd_m});
         end
         checks++;
         if ({m_ack, m_ve, m_busy, m_own} !== {exp_ack, (ph == 3) && mis_m, (ph != 0), own_m}) begin
            errors++;
            $display("FAIL rand_handshake cyc=%0d act=%b exp=%b", cyc, {m_ack, m_ve, m_busy, m_own}, {exp_ack, (ph == 3) && mis_m, (ph != 0), own_m});
         end
         checks++;
         if (m_ec !== 8'(ec_m)) begin errors++; $display("FAIL rand_err_count cyc=%0d act=%0d exp=%0d", cyc, m_ec, ec_m); end
         if (ph == 3) req[w_m] = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               req_data[i*W +: W] = 10'($urandom());
            end else if ($urandom_range(0, 7) == 0) begin
               req_data[i*W +: W] = 10'($urandom());
            end
         end
         if ($urandom_range(0, 15) == 0) fault = ~fault;
      end
      req = '0; fault = 1'b0;
      repeat (20) tick();
      $display("test_random sel=%0d done txns=%0d", s, txns);
   endtask

   initial begin
      reset = 1'b1; req = '0; req_data = '0; fault = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_min_hold();
      test_verify_err();
      test_data_latch();
      test_reset_mid();
      test_random(0);
      test_random(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
